// File: rtl/adc_init_sequencer.sv
// Power-up SPI configuration sequencer for the AD9648: optional chip-ID check, then a fixed write list.
// Optional feature macro: ADC_INIT_ID_CHECK_EN compiles in the chip-ID read and comparison.
module adc_init_sequencer #(
  parameter int unsigned          TxRegWidth      = 24,
  parameter int unsigned          RxRegWidth      = 8,
  parameter logic [RxRegWidth-1:0] ChipId         = 8'h88,
  parameter logic [7:0]           OutputMode      = 8'h00,
  parameter int unsigned          GapCycles       = 16,
  parameter int unsigned          ResetWaitCycles = 1000,
  parameter int unsigned          TimeoutCycles   = 4096
) (
  input  logic                  clk_sys_i,
  input  logic                  rst_sys_clk_i,
  input  logic                  start_i,
  output logic                  start_transfer_o,
  output logic [TxRegWidth-1:0] tx_data_o,
  input  logic                  transfer_done_i,
  input  logic [RxRegWidth-1:0] rx_data_i,
  output logic                  busy_o,
  output logic                  config_done_o,
  output logic                  error_o,
  output logic [1:0]            err_code_o
);

  localparam int unsigned TimeoutW = $clog2(TimeoutCycles + 1);
  localparam int unsigned GapMax   = (ResetWaitCycles > GapCycles) ? ResetWaitCycles : GapCycles;
  localparam int unsigned GapW     = $clog2(GapMax + 1);

  // Wait states last exactly TimeoutCycles cycles when no done arrives.
  localparam logic [TimeoutW-1:0] TimeoutLast  = TimeoutW'(TimeoutCycles - 1);
  localparam logic [GapW-1:0]     ResetGapLoad = GapW'(ResetWaitCycles - 1);
  localparam logic [GapW-1:0]     ShortGapLoad = GapW'(GapCycles - 1);

  localparam logic [1:0] ErrNone     = 2'b00;
  localparam logic [1:0] ErrTimeout  = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
`ifdef ADC_INIT_ID_CHECK_EN
    StIdReq,
    StIdWait,
`endif
    StWrReq,
    StWrWait,
    StGap,
    StDone,
    StError
  } state_e;

  function automatic logic [TxRegWidth-1:0] make_frame(input logic       rd,
                                                       input logic [12:0] addr,
                                                       input logic [7:0]  data);
    return TxRegWidth'({rd, 2'b00, addr, data});
  endfunction

  function automatic logic [TxRegWidth-1:0] wr_frame(input logic [1:0] idx);
    logic [12:0] addr;
    logic [7:0]  data;
    case (idx)
      2'd0:    begin addr = 13'h000; data = 8'h3C;      end
      2'd1:    begin addr = 13'h014; data = OutputMode; end
      default: begin addr = 13'h0FF; data = 8'h01;      end
    endcase
    return make_frame(1'b0, addr, data);
  endfunction

  state_e                r_state, w_state_d;
  logic [1:0]            r_idx, w_idx_d;
  logic [TimeoutW-1:0]   r_to_cnt, w_to_cnt_d;
  logic [GapW-1:0]       r_gap_cnt, w_gap_cnt_d;
  logic                  r_start_transfer, w_start_transfer_d;
  logic [TxRegWidth-1:0] r_tx_data, w_tx_data_d;
  logic                  r_busy, w_busy_d;
  logic                  r_config_done, w_config_done_d;
  logic                  r_error, w_error_d;
  logic [1:0]            r_err_code, w_err_code_d;
  logic                  w_in_wait;

`ifdef ADC_INIT_ID_CHECK_EN
  assign w_in_wait = (r_state == StIdWait) || (r_state == StWrWait);
`else
  assign w_in_wait = (r_state == StWrWait);
  logic w_unused_id;
  assign w_unused_id = ^{rx_data_i, ChipId};
`endif

  always_comb begin
    w_state_d          = r_state;
    w_idx_d            = r_idx;
    w_to_cnt_d         = r_to_cnt;
    w_gap_cnt_d        = r_gap_cnt;
    w_start_transfer_d = 1'b0;
    w_tx_data_d        = r_tx_data;
    w_busy_d           = r_busy;
    w_config_done_d    = r_config_done;
    w_error_d          = r_error;
    w_err_code_d       = r_err_code;

    unique case (r_state)
      StIdle, StDone, StError: begin
        if (start_i) begin
          w_busy_d        = 1'b1;
          w_config_done_d = 1'b0;
          w_error_d       = 1'b0;
          w_err_code_d    = ErrNone;
          w_idx_d         = 2'd0;
`ifdef ADC_INIT_ID_CHECK_EN
          w_state_d       = StIdReq;
`else
          w_state_d       = StWrReq;
`endif
        end
      end
`ifdef ADC_INIT_ID_CHECK_EN
      StIdReq: begin
        w_start_transfer_d = 1'b1;
        w_tx_data_d        = make_frame(1'b1, 13'h001, 8'h00);
        w_to_cnt_d         = '0;
        w_state_d          = StIdWait;
      end
      StIdWait: begin
        if (transfer_done_i) begin
          if (rx_data_i == ChipId) begin
            w_idx_d     = 2'd0;
            w_gap_cnt_d = ShortGapLoad;
            w_state_d   = StGap;
          end else begin
            w_busy_d     = 1'b0;
            w_error_d    = 1'b1;
            w_err_code_d = 2'b01;
            w_state_d    = StError;
          end
        end
      end
`endif
      StWrReq: begin
        w_start_transfer_d = 1'b1;
        w_tx_data_d        = wr_frame(r_idx);
        w_to_cnt_d         = '0;
        w_state_d          = StWrWait;
      end
      StWrWait: begin
        if (transfer_done_i) begin
          if (r_idx == 2'd2) begin
            w_busy_d        = 1'b0;
            w_config_done_d = 1'b1;
            w_state_d       = StDone;
          end else begin
            // The soft reset needs the long settle time before the next write.
            w_gap_cnt_d = (r_idx == 2'd0) ? ResetGapLoad : ShortGapLoad;
            w_idx_d     = r_idx + 2'd1;
            w_state_d   = StGap;
          end
        end
      end
      StGap: begin
        if (r_gap_cnt == '0) begin
          w_state_d = StWrReq;
        end else begin
          w_gap_cnt_d = r_gap_cnt - GapW'(1);
        end
      end
      default: w_state_d = StIdle;
    endcase

    // Done takes priority over a timeout reached in the same cycle.
    if (w_in_wait && !transfer_done_i) begin
      if (r_to_cnt == TimeoutLast) begin
        w_busy_d     = 1'b0;
        w_error_d    = 1'b1;
        w_err_code_d = ErrTimeout;
        w_state_d    = StError;
      end else begin
        w_to_cnt_d = r_to_cnt + TimeoutW'(1);
      end
    end
  end

  always_ff @(posedge clk_sys_i or posedge rst_sys_clk_i) begin
    if (rst_sys_clk_i) begin
      r_state          <= StIdle;
      r_idx            <= 2'd0;
      r_to_cnt         <= '0;
      r_gap_cnt        <= '0;
      r_start_transfer <= 1'b0;
      r_tx_data        <= '0;
      r_busy           <= 1'b0;
      r_config_done    <= 1'b0;
      r_error          <= 1'b0;
      r_err_code       <= ErrNone;
    end else begin
      r_state          <= w_state_d;
      r_idx            <= w_idx_d;
      r_to_cnt         <= w_to_cnt_d;
      r_gap_cnt        <= w_gap_cnt_d;
      r_start_transfer <= w_start_transfer_d;
      r_tx_data        <= w_tx_data_d;
      r_busy           <= w_busy_d;
      r_config_done    <= w_config_done_d;
      r_error          <= w_error_d;
      r_err_code       <= w_err_code_d;
    end
  end

  assign start_transfer_o = r_start_transfer;
  assign tx_data_o        = r_tx_data;
  assign busy_o           = r_busy;
  assign config_done_o    = r_config_done;
  assign error_o          = r_error;
  assign err_code_o       = r_err_code;

endmodule

// File: tb/tb_adc_init_sequencer.sv
// Scoreboard bench for adc_init_sequencer: expected frames/status are queued at launch and
// consumed by an independent monitor; an SPI responder model answers each transfer.
module tb_adc_init_sequencer;

  localparam int unsigned TimeoutCycles   = 4096;
  localparam int unsigned ResetWaitCycles = 1000;
  localparam int unsigned GapCycles       = 16;
  localparam logic [7:0]  ChipId          = 8'h88;
  localparam logic [7:0]  OutputMode      = 8'h00;
`ifdef ADC_INIT_ID_CHECK_EN
  localparam int          IdXfers         = 1;
`else
  localparam int          IdXfers         = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        start_transfer;
  logic [23:0] tx_data;
  logic        transfer_done;
  logic [7:0]  rx_data;
  logic        busy;
  logic        config_done;
  logic        error;
  logic [1:0]  err_code;

  always #5 clk = ~clk;

  adc_init_sequencer #(
    .TxRegWidth      (24),
    .RxRegWidth      (8),
    .ChipId          (ChipId),
    .OutputMode      (OutputMode),
    .GapCycles       (GapCycles),
    .ResetWaitCycles (ResetWaitCycles),
    .TimeoutCycles   (TimeoutCycles)
  ) dut (
    .clk_sys_i        (clk),
    .rst_sys_clk_i    (rst),
    .start_i          (start),
    .start_transfer_o (start_transfer),
    .tx_data_o        (tx_data),
    .transfer_done_i  (transfer_done),
    .rx_data_i        (rx_data),
    .busy_o           (busy),
    .config_done_o    (config_done),
    .error_o          (error),
    .err_code_o       (err_code)
  );

  typedef struct {
    logic       done;
    logic       err;
    logic [1:0] code;
  } status_t;

  int          total = 0;
  int          bad   = 0;
  int unsigned cyc   = 0;
  logic [23:0] frame_q[$];
  status_t     status_q[$];
  int          st_count = 0;

  // SPI responder controls
  logic [7:0] id_resp   = 8'h88;
  int         hang_xfer = 0;
  int         lat_min   = 20;
  int         lat_max   = 20;
  int         xfer_num  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: the run is the optional ID read followed by the three writes, cut short by an
  // ID mismatch or by the transfer that never completes.
  function automatic void expect_run(input logic [7:0] idr, input int hang);
    logic [23:0] xfers[$];
    int          addrs[3];
    logic [7:0]  datas[3];
    status_t     s;
    addrs = '{'h000, 'h014, 'h0FF};
    datas = '{8'h3C, OutputMode, 8'h01};
    if (IdXfers == 1) xfers.push_back(24'h800000 | (24'h001 << 8));
    for (int i = 0; i < 3; i++) xfers.push_back(24'((addrs[i] << 8) | datas[i]));
    for (int i = 0; i < xfers.size(); i++) begin
      frame_q.push_back(xfers[i]);
      if (i + 1 == hang) begin
        s = '{done: 1'b0, err: 1'b1, code: 2'b10};
        status_q.push_back(s);
        return;
      end
      if (xfers[i][23] && idr != ChipId) begin
        s = '{done: 1'b0, err: 1'b1, code: 2'b01};
        status_q.push_back(s);
        return;
      end
    end
    s = '{done: 1'b1, err: 1'b0, code: 2'b00};
    status_q.push_back(s);
  endfunction

  // SPI responder: done pulse a few cycles after each request, unless told to hang.
  initial begin
    int lat;
    transfer_done = 1'b0;
    rx_data       = 8'h00;
    forever begin
      @(negedge clk);
      if (start_transfer && !rst) begin
        xfer_num++;
        if (xfer_num != hang_xfer) begin
          lat = int'($urandom_range(lat_max, lat_min));
          repeat (lat) @(posedge clk);
          #1;
          transfer_done = 1'b1;
          rx_data       = id_resp;
          @(posedge clk);
          #1;
          transfer_done = 1'b0;
          rx_data       = 8'h00;
        end
      end
    end
  end

  // Monitor
  initial begin
    logic        prev_st   = 1'b0;
    logic        prev_done = 1'b0;
    logic        prev_err  = 1'b0;
    int unsigned last_st_cyc   = 0;
    int unsigned last_done_cyc = 0;
    logic [23:0] last_frame    = 24'h0;
    status_t     s;
    forever begin
      @(negedge clk);
      if (rst) last_frame = 24'h0;
      if (start_transfer) begin
        st_count++;
        check("start_pulse_single", prev_st, 1'b0);
        if (last_frame == 24'h00003C)
          check("reset_wait_ge", (cyc - last_done_cyc) >= ResetWaitCycles, 1'b1);
        check("frame_expected", frame_q.size() != 0, 1'b1);
        if (frame_q.size() != 0) check("frame", tx_data, frame_q.pop_front());
        last_frame  = tx_data;
        last_st_cyc = cyc;
      end
      if (transfer_done) last_done_cyc = cyc;
      if ((config_done && !prev_done) || (error && !prev_err)) begin
        check("status_expected", status_q.size() != 0, 1'b1);
        if (status_q.size() != 0) begin
          s = status_q.pop_front();
          check("config_done", config_done, s.done);
          check("error", error, s.err);
          check("err_code", err_code, s.code);
          check("busy_fall", busy, 1'b0);
          if (s.code == 2'b10) check("timeout_cycles", cyc - last_st_cyc, TimeoutCycles);
          if (s.done) check("done_latency", cyc - last_done_cyc, 1);
        end
      end
      prev_st   = start_transfer;
      prev_done = config_done;
      prev_err  = error;
    end
  end

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic launch(input logic [7:0] idr, input int hang, input int lmin, input int lmax);
    id_resp   = idr;
    hang_xfer = hang;
    lat_min   = lmin;
    lat_max   = lmax;
    xfer_num  = 0;
    expect_run(idr, hang);
    @(posedge clk);
    #1 start = 1'b1;
    @(negedge clk);
    check("busy_before_start", busy, 1'b0);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("busy_after_start", busy, 1'b1);
    check("done_cleared", config_done, 1'b0);
    check("error_cleared", error, 1'b0);
    check("code_cleared", err_code, 2'b00);
  endtask

  task automatic wait_run(input int budget);
    int n = 0;
    while (status_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("run_finished", status_q.size(), 0);
    check("frames_consumed", frame_q.size(), 0);
    repeat (5) @(negedge clk);
  endtask

  initial begin
    logic [7:0] bad_id;
    int         n;
    int         target;
    rst   = 1'b1;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_start_transfer", start_transfer, 1'b0);
    check("rst_tx_data", tx_data, 24'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_config_done", config_done, 1'b0);
    check("rst_error", error, 1'b0);
    check("rst_err_code", err_code, 2'b00);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);

    // Happy path with a start pulse mid-sequence that must be ignored
    launch(ChipId, 0, 20, 20);
    repeat (100) @(negedge clk);
    pulse_start();
    @(negedge clk);
    check("busy_ignored_start", busy, 1'b1);
    wait_run(20000);

    // Restart from DONE
    launch(ChipId, 0, 1, 40);
    wait_run(20000);

`ifdef ADC_INIT_ID_CHECK_EN
    bad_id = 8'($urandom);
    if (bad_id == ChipId) bad_id = bad_id ^ 8'h01;
    launch(bad_id, 0, 1, 40);
    wait_run(20000);
`endif

    // Second write never completes
    launch(ChipId, IdXfers + 2, 1, 40);
    wait_run(20000);

    // Reset during the first write's wait
    target = st_count + IdXfers + 1;
    launch(ChipId, 0, 30, 30);
    n = 0;
    while (st_count < target && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("reached_wr_wait", st_count >= target, 1'b1);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_start_transfer", start_transfer, 1'b0);
    check("async_tx_data", tx_data, 24'h0);
    check("async_busy", busy, 1'b0);
    check("async_config_done", config_done, 1'b0);
    check("async_error", error, 1'b0);
    check("async_err_code", err_code, 2'b00);
    frame_q.delete();
    status_q.delete();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    target = st_count;
    repeat (300) @(negedge clk);
    check("no_pulses_after_reset", st_count, target);
    check("idle_after_reset", busy, 1'b0);

    // Fresh run after reset
    launch(ChipId, 0, 1, 40);
    wait_run(20000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
